// File: rtl/motor_ramp_sequencer_if.sv
// Command and drive bundle between the speed-command source and motor_ramp_sequencer.
// master = command source / observer, slave = the sequencer itself.
interface motor_ramp_sequencer_if;
   logic              run_req;
   logic              cmd_valid;
   logic signed [9:0] target_left;
   logic signed [9:0] target_right;
   logic              motor_on;
   logic [9:0]        speed_left;
   logic              dir_left;
   logic [9:0]        speed_right;
   logic              dir_right;
   logic              at_target;
   logic [1:0]        state_out;

   modport master (
      output run_req, cmd_valid, target_left, target_right,
      input  motor_on, speed_left, dir_left, speed_right, dir_right, at_target, state_out
   );

   modport slave (
      input  run_req, cmd_valid, target_left, target_right,
      output motor_on, speed_left, dir_left, speed_right, dir_right, at_target, state_out
   );
endinterface

// File: rtl/motor_ramp_sequencer.sv
// Drives the left/right stepper drivers: enable, settle delay, acceleration-limited ramps.
// Define MOTOR_WATCHDOG_EN to zero the targets when commands stop arriving while in RUN.
module motor_ramp_sequencer #(
   parameter logic [9:0] MAX_SPEED     = 10'd400,
   parameter logic [9:0] ACCEL_STEP    = 10'd10,
   parameter int         RAMP_DIV      = 100000,
   parameter int         SETTLE_CYCLES = 1000000
`ifdef MOTOR_WATCHDOG_EN
   ,
   parameter int         WDOG_CYCLES   = 50000000
`endif
) (
   input logic                   clock,
   input logic                   reset,
   motor_ramp_sequencer_if.slave bus
);
   localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [TW-1:0] TICK_LAST   = TW'(RAMP_DIV - 1);
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2, STOP = 2'd3} state_t;

   state_t          state_reg;
   logic            motor_on_reg;
   logic            at_target_reg;
   logic [TW-1:0]   tick_cnt_reg;
   logic [SW-1:0]   settle_cnt_reg;
   logic [1:0][9:0] target_reg;
   logic [1:0][9:0] speed_reg;
   logic [1:0][9:0] speed_next;
   logic [1:0]      dir_reg;
   logic [1:0]      dir_next;
   logic [1:0]      match;
   logic            tick;
   logic            zero_tgt;

   // Returns {dir, speed} after one ramp tick: decelerate, then flip, then approach magnitude.
   function automatic logic [10:0] ramp_step(input logic dir, input logic [9:0] spd,
                                             input logic des, input logic [9:0] mag);
      logic [10:0] res;
      logic [9:0]  d;
      if (dir != des && spd != 10'd0) begin
         d   = (spd < ACCEL_STEP) ? spd : ACCEL_STEP;
         res = {dir, spd - d};
      end else if (dir != des && mag != 10'd0) begin
         res = {des, spd};
      end else if (spd < mag) begin
         d   = ((mag - spd) < ACCEL_STEP) ? (mag - spd) : ACCEL_STEP;
         res = {dir, spd + d};
      end else begin
         d   = ((spd - mag) < ACCEL_STEP) ? (spd - mag) : ACCEL_STEP;
         res = {dir, spd - d};
      end
      return res;
   endfunction

`ifdef MOTOR_WATCHDOG_EN
   logic [31:0] wdog_cnt_reg;
   logic        wdog_flag_reg;
   assign zero_tgt = (state_reg == STOP) || wdog_flag_reg;
`else
   assign zero_tgt = (state_reg == STOP);
`endif

   assign tick = (tick_cnt_reg == TICK_LAST);

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [9:0] abs_t;
      logic [9:0] mag;
      logic       des;
      assign abs_t = target_reg[gi][9] ? (~target_reg[gi] + 10'd1) : target_reg[gi];
      assign mag   = zero_tgt ? 10'd0 : ((abs_t > MAX_SPEED) ? MAX_SPEED : abs_t);
      assign des   = zero_tgt ? 1'b1 : ~target_reg[gi][9];
      assign {dir_next[gi], speed_next[gi]} = ramp_step(dir_reg[gi], speed_reg[gi], des, mag);
      // A zero magnitude never demands a direction, so either dir counts as matched.
      assign match[gi] = (speed_reg[gi] == mag) && ((dir_reg[gi] == des) || (mag == 10'd0));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         motor_on_reg   <= 1'b0;
         at_target_reg  <= 1'b0;
         tick_cnt_reg   <= '0;
         settle_cnt_reg <= '0;
         target_reg     <= '0;
         speed_reg      <= '0;
         dir_reg        <= 2'b11;
`ifdef MOTOR_WATCHDOG_EN
         wdog_cnt_reg   <= '0;
         wdog_flag_reg  <= 1'b0;
`endif
      end else begin
`ifdef MOTOR_WATCHDOG_EN
         if (bus.cmd_valid) begin
            target_reg    <= {bus.target_right, bus.target_left};
            wdog_cnt_reg  <= '0;
            wdog_flag_reg <= 1'b0;
         end else if (wdog_cnt_reg == 32'(WDOG_CYCLES)) begin
            target_reg    <= '0;
            wdog_flag_reg <= 1'b1;
         end else if (state_reg == RUN) begin
            wdog_cnt_reg  <= wdog_cnt_reg + 32'd1;
         end
`else
         if (bus.cmd_valid)
            target_reg <= {bus.target_right, bus.target_left};
`endif
         at_target_reg <= (state_reg == RUN) && (&match);

         if (state_reg == RUN || state_reg == STOP) begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);
            if (tick) begin
               speed_reg <= speed_next;
               dir_reg   <= dir_next;
            end
         end

         case (state_reg)
            IDLE: if (bus.run_req) begin
               state_reg      <= SETTLE;
               settle_cnt_reg <= SETTLE_LOAD;
               motor_on_reg   <= 1'b1;
            end
            SETTLE: if (!bus.run_req) begin
               state_reg    <= IDLE;
               motor_on_reg <= 1'b0;
            end else if (settle_cnt_reg == '0) begin
               state_reg    <= RUN;
               tick_cnt_reg <= '0;
            end else begin
               settle_cnt_reg <= settle_cnt_reg - SW'(1);
            end
            RUN: if (!bus.run_req)
               state_reg <= STOP;
            STOP: if (bus.run_req) begin
               state_reg <= RUN;
            end else if (speed_reg == '0) begin
               state_reg    <= IDLE;
               motor_on_reg <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.motor_on    = motor_on_reg;
   assign bus.speed_left  = speed_reg[0];
   assign bus.dir_left    = dir_reg[0];
   assign bus.speed_right = speed_reg[1];
   assign bus.dir_right   = dir_reg[1];
   assign bus.at_target   = at_target_reg;
   assign bus.state_out   = state_reg;
endmodule
